// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the multi-cycle RV32I control unit
package ctrl_pkg;
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_TRAP
    } state_t;
    typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT} aluop_t;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [1:0] SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RS1 = 2'b10;
    localparam logic [1:0] SRCB_RS2 = 2'b00, SRCB_IMM = 2'b01, SRCB_4 = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00, RES_MEM = 2'b01, RES_ALU = 2'b10;
    localparam logic [1:0] IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10, IMM_J = 2'b11;
endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: instruction/handshake inputs and datapath controls of the control unit
interface multicycle_control_if #(parameter int ALU_CTRL_W = 3);
    logic [31:0] Instr;
    logic Zero, mem_ready;
    logic mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
    logic [1:0] ALUSrcA, ALUSrcB, ImmSrc, ResultSrc;
    logic [ALU_CTRL_W-1:0] ALUctrl;
    logic illegal;
    modport master (
        input Instr, Zero, mem_ready,
        output mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
        output ALUSrcA, ALUSrcB, ImmSrc, ResultSrc, ALUctrl, illegal
    );
    modport slave (
        output Instr, Zero, mem_ready,
        input mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
        input ALUSrcA, ALUSrcB, ImmSrc, ResultSrc, ALUctrl, illegal
    );
endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// alu_decoder: maps ALUop/funct fields to an ALU operation and flags unsupported funct3
module alu_decoder import ctrl_pkg::*; (
    input  aluop_t     aluop,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       op5,
    output logic [2:0] alu_ctrl,
    output logic       funct_ok
);
    assign funct_ok = funct3 inside {3'b000, 3'b010, 3'b110, 3'b111};
    assign alu_ctrl = aluop == ALUOP_ADD ? ALU_ADD :
                      aluop == ALUOP_SUB ? ALU_SUB :
                      funct3 == 3'b010   ? ALU_SLT :
                      funct3 == 3'b110   ? ALU_OR  :
                      funct3 == 3'b111   ? ALU_AND :
                      (funct7 && op5)    ? ALU_SUB : ALU_ADD;
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: registered FSM sequencing RV32I instructions over a shared ALU and memory port
module multicycle_control import ctrl_pkg::*; #(
    parameter int ALU_CTRL_W = 3,
    parameter bit BNE_EN     = 1'b1
) (
    input logic clk,
    input logic rst,
    multicycle_control_if.master bus
);
    state_t state, next;
    aluop_t aluop;
    logic [6:0] op;
    logic [2:0] f3, alu_ctrl;
    logic funct_ok, br_ok, illegal_q, unused_instr;
    assign op = bus.Instr[6:0];
    assign f3 = bus.Instr[14:12];
    assign unused_instr = ^{bus.Instr[31], bus.Instr[29:15], bus.Instr[11:7]};
    assign br_ok = f3 == 3'b000 || (BNE_EN && f3 == 3'b001);
    assign aluop = (state == S_EXECR || state == S_EXECI) ? ALUOP_FUNCT :
                   state == S_BRANCH ? ALUOP_SUB : ALUOP_ADD;
    alu_decoder u_dec (
        .aluop(aluop), .funct3(f3), .funct7(bus.Instr[30]), .op5(bus.Instr[5]),
        .alu_ctrl(alu_ctrl), .funct_ok(funct_ok)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state <= next;
            if (state == S_DECODE && next == S_TRAP) illegal_q <= 1'b1;
        end
    end
    always_comb begin
        next = state;
        case (state)
            S_FETCH:  next = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: case (op)
                OPC_LOAD, OPC_STORE: next = S_MEMADR;
                OPC_OP:              next = funct_ok ? S_EXECR : S_TRAP;
                OPC_OP_IMM:          next = funct_ok ? S_EXECI : S_TRAP;
                OPC_BRANCH:          next = br_ok ? S_BRANCH : S_TRAP;
                OPC_JAL:             next = S_JAL;
                default:             next = S_TRAP;
            endcase
            S_MEMADR: next = op[5] ? S_MEMWR : S_MEMRD;
            S_MEMRD:  next = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  next = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_MEMWB, S_ALUWB, S_BRANCH: next = S_FETCH;
            S_EXECR, S_EXECI, S_JAL:    next = S_ALUWB;
            default:  next = S_TRAP;
        endcase
    end
    always_comb begin
        bus.mem_req = 1'b0;
        bus.MemWrite = 1'b0;
        bus.AdrSrc = 1'b0;
        bus.IRWrite = 1'b0;
        bus.PCWrite = 1'b0;
        bus.RegWrite = 1'b0;
        bus.ALUSrcA = SRCA_PC;
        bus.ALUSrcB = SRCB_RS2;
        bus.ImmSrc = IMM_I;
        bus.ResultSrc = RES_ALUOUT;
        case (state)
            S_FETCH: begin
                bus.mem_req = 1'b1;
                bus.ALUSrcB = SRCB_4;
                bus.ResultSrc = RES_ALU;
                bus.IRWrite = bus.mem_ready;
                bus.PCWrite = bus.mem_ready;
            end
            S_DECODE: begin
                bus.ALUSrcA = SRCA_OLDPC;
                bus.ALUSrcB = SRCB_IMM;
                bus.ImmSrc = IMM_B;
            end
            S_MEMADR: begin
                bus.ALUSrcA = SRCA_RS1;
                bus.ALUSrcB = SRCB_IMM;
                bus.ImmSrc = op[5] ? IMM_S : IMM_I;
            end
            S_MEMRD: begin
                bus.mem_req = 1'b1;
                bus.AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                bus.ResultSrc = RES_MEM;
                bus.RegWrite = 1'b1;
            end
            S_MEMWR: begin
                bus.mem_req = 1'b1;
                bus.MemWrite = 1'b1;
                bus.AdrSrc = 1'b1;
                bus.ImmSrc = IMM_S;
            end
            S_EXECR: bus.ALUSrcA = SRCA_RS1;
            S_EXECI: begin
                bus.ALUSrcA = SRCA_RS1;
                bus.ALUSrcB = SRCB_IMM;
            end
            S_ALUWB: bus.RegWrite = 1'b1;
            S_BRANCH: begin
                bus.ALUSrcA = SRCA_RS1;
                bus.PCWrite = bus.Zero ^ (BNE_EN & f3[0]);
            end
            S_JAL: begin
                bus.ALUSrcA = SRCA_OLDPC;
                bus.ALUSrcB = SRCB_4;
                bus.ImmSrc = IMM_J;
                bus.PCWrite = 1'b1;
            end
            default: ;
        endcase
        if (rst) begin
            bus.mem_req = 1'b0;
            bus.MemWrite = 1'b0;
            bus.IRWrite = 1'b0;
            bus.PCWrite = 1'b0;
            bus.RegWrite = 1'b0;
        end
    end
    assign bus.ALUctrl = ALU_CTRL_W'(alu_ctrl);
    assign bus.illegal = illegal_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: random and directed instructions checked against a per-instruction step model
module tb_multicycle_control;
    localparam bit BNE = 1'b1;
    localparam int ST_FETCH = 0, ST_DEC = 1, ST_MAL = 2, ST_MAS = 3, ST_MRD = 4, ST_MWB = 5, ST_MWR = 6;
    localparam int ST_EXR = 7, ST_EXI = 8, ST_WB = 9, ST_BR = 10, ST_JAL = 11, ST_TRAP = 12;
    typedef struct packed {
        logic req, mw, adr, irw, pcw, rw;
        logic [1:0] a, b, imm, res;
        logic [2:0] alu;
        logic ill;
    } out_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run = 1'b0;
    int n_checks = 0;
    int n_fail = 0;
    int q[$];
    out_t snap;
    out_t hist[32];
    always #5 clk = ~clk;
    multicycle_control_if #(.ALU_CTRL_W(3)) bus();
    multicycle_control #(.ALU_CTRL_W(3), .BNE_EN(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));
    function automatic out_t dut_out();
        out_t o;
        o.req = bus.mem_req; o.mw = bus.MemWrite; o.adr = bus.AdrSrc;
        o.irw = bus.IRWrite; o.pcw = bus.PCWrite; o.rw = bus.RegWrite;
        o.a = bus.ALUSrcA; o.b = bus.ALUSrcB; o.imm = bus.ImmSrc; o.res = bus.ResultSrc;
        o.alu = bus.ALUctrl; o.ill = bus.illegal;
        return o;
    endfunction
    function automatic logic [2:0] funct_alu(logic [31:0] ins);
        case (ins[14:12])
            3'b000:  return (ins[30] & ins[5]) ? 3'd1 : 3'd0;
            3'b010:  return 3'd5;
            3'b110:  return 3'd3;
            3'b111:  return 3'd2;
            default: return 3'd0;
        endcase
    endfunction
    function automatic out_t model_out(int st, logic [31:0] ins, logic z, logic rd, logic r);
        out_t o = '0;
        case (st)
            ST_FETCH: begin o.req = 1'b1; o.b = 2'd2; o.res = 2'd2; o.irw = rd; o.pcw = rd; end
            ST_DEC:   begin o.a = 2'd1; o.b = 2'd1; o.imm = 2'd2; end
            ST_MAL:   begin o.a = 2'd2; o.b = 2'd1; end
            ST_MAS:   begin o.a = 2'd2; o.b = 2'd1; o.imm = 2'd1; end
            ST_MRD:   begin o.req = 1'b1; o.adr = 1'b1; end
            ST_MWB:   begin o.res = 2'd1; o.rw = 1'b1; end
            ST_MWR:   begin o.req = 1'b1; o.mw = 1'b1; o.adr = 1'b1; o.imm = 2'd1; end
            ST_EXR:   begin o.a = 2'd2; o.alu = funct_alu(ins); end
            ST_EXI:   begin o.a = 2'd2; o.b = 2'd1; o.alu = funct_alu(ins); end
            ST_WB:    o.rw = 1'b1;
            ST_BR:    begin o.a = 2'd2; o.alu = 3'd1; o.pcw = z ^ (BNE & ins[12]); end
            ST_JAL:   begin o.a = 2'd1; o.b = 2'd2; o.imm = 2'd3; o.pcw = 1'b1; end
            default:  o.ill = 1'b1;
        endcase
        if (r) begin o.req = 1'b0; o.mw = 1'b0; o.irw = 1'b0; o.pcw = 1'b0; o.rw = 1'b0; end
        return o;
    endfunction
    // An instruction is the list of steps it occupies after FETCH; waits repeat a step.
    function automatic void plan(logic [31:0] ins);
        logic [2:0] f3 = ins[14:12];
        logic fok = f3 == 3'd0 || f3 == 3'd2 || f3 == 3'd6 || f3 == 3'd7;
        q.delete();
        q.push_back(ST_DEC);
        case (ins[6:0])
            7'b0000011: begin q.push_back(ST_MAL); q.push_back(ST_MRD); q.push_back(ST_MWB); end
            7'b0100011: begin q.push_back(ST_MAS); q.push_back(ST_MWR); end
            7'b0110011: if (fok) begin q.push_back(ST_EXR); q.push_back(ST_WB); end else q.push_back(ST_TRAP);
            7'b0010011: if (fok) begin q.push_back(ST_EXI); q.push_back(ST_WB); end else q.push_back(ST_TRAP);
            7'b1100011: q.push_back((f3 == 3'd0 || (BNE && f3 == 3'd1)) ? ST_BR : ST_TRAP);
            7'b1101111: begin q.push_back(ST_JAL); q.push_back(ST_WB); end
            default:    q.push_back(ST_TRAP);
        endcase
    endfunction
    function automatic int cur_step();
        return q.size() == 0 ? ST_FETCH : q[0];
    endfunction
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    always @(negedge clk) if (run) begin
        out_t e;
        e = model_out(cur_step(), bus.Instr, bus.Zero, bus.mem_ready, rst);
        check($sformatf("model step %0d", cur_step()), 32'(dut_out()), 32'(e));
    end
    always @(posedge clk) if (run) begin
        if (rst) q.delete();
        else if (q.size() == 0) begin
            if (bus.mem_ready) plan(bus.Instr);
        end else if (!(q[0] == ST_TRAP || ((q[0] == ST_MRD || q[0] == ST_MWR) && !bus.mem_ready)))
            void'(q.pop_front());
    end
    task automatic cyc(input logic r, input logic rd);
        rst = r;
        bus.mem_ready = rd;
        @(negedge clk);
        snap = dut_out();
        @(posedge clk);
        #1;
    endtask
    task automatic run_instr(input logic [31:0] ins, input logic z, input logic [31:0] low, output int len);
        bus.Instr = ins;
        bus.Zero = z;
        len = 0;
        do begin
            cyc(1'b0, !low[len]);
            hist[len] = snap;
            len++;
        end while (q.size() != 0 && len < 32);
        if (len >= 32) check("instruction cycle bound", 32'(len), 32'd0);
    endtask
    task automatic trap_test(input logic [31:0] ins, input string name);
        logic en = 1'b0;
        bus.Instr = ins;
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b1);
            en |= snap.req | snap.mw | snap.irw | snap.pcw | snap.rw;
        end
        check({name, " illegal"}, 32'(snap.ill), 32'd1);
        check({name, " enables"}, 32'(en), 32'd0);
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b0);
        check({name, " illegal after rst"}, 32'(snap.ill), 32'd0);
        check({name, " fetch after rst"}, 32'({snap.req, snap.irw}), 32'b10);
    endtask
    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(7);
        w[6:0] = k == 0 ? 7'b0000011 : k == 1 ? 7'b0100011 : k == 2 ? 7'b0110011 :
                 k == 3 ? 7'b0010011 : k == 4 ? 7'b1100011 : k == 5 ? 7'b1101111 :
                 k == 6 ? 7'($urandom) : 7'b0110011;
        return w;
    endfunction
    initial begin
        int len;
        int tc;
        bus.Instr = 32'h00000013;
        bus.Zero = 1'b0;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        run = 1'b1;
        cyc(1'b1, 1'b1);
        check("reset mem_req", 32'(snap.req), 32'd0);
        check("reset IRWrite", 32'(snap.irw), 32'd0);
        check("reset illegal", 32'(snap.ill), 32'd0);
        run_instr(32'h00208033, 1'b0, 32'h0, len);
        check("add cycles", 32'(len), 32'd4);
        check("add ALUctrl", 32'(hist[2].alu), 32'd0);
        check("add RegWrite in ALUWB", 32'(hist[3].rw), 32'd1);
        check("add RegWrite early", 32'(hist[0].rw | hist[1].rw | hist[2].rw), 32'd0);
        run_instr(32'h0000A103, 1'b0, 32'h18, len);
        check("lw cycles", 32'(len), 32'd7);
        check("lw mem_req in MEMRD", 32'(hist[3].req & hist[4].req & hist[5].req), 32'd1);
        check("lw AdrSrc in MEMRD", 32'(hist[3].adr & hist[4].adr & hist[5].adr), 32'd1);
        check("lw ResultSrc in MEMWB", 32'(hist[6].res), 32'd1);
        run_instr(32'h00208063, 1'b1, 32'h0, len);
        check("beq cycles", 32'(len), 32'd3);
        check("beq taken PCWrite", 32'(hist[2].pcw), 32'd1);
        run_instr(32'h00208063, 1'b0, 32'h0, len);
        check("beq not taken PCWrite", 32'(hist[2].pcw), 32'd0);
        run_instr(32'h00209063, 1'b1, 32'h0, len);
        check("bne zero PCWrite", 32'(hist[2].pcw), 32'd0);
        run_instr(32'h00209063, 1'b0, 32'h0, len);
        check("bne nonzero PCWrite", 32'(hist[2].pcw), 32'd1);
        run_instr(32'h40208033, 1'b0, 32'h0, len);
        check("sub ALUctrl", 32'(hist[2].alu), 32'd1);
        run_instr(32'h40008093, 1'b0, 32'h0, len);
        check("addi bit30 ALUctrl", 32'(hist[2].alu), 32'd0);
        run_instr(32'h0000006F, 1'b0, 32'h0, len);
        check("jal cycles", 32'(len), 32'd4);
        check("jal PCWrite", 32'(hist[2].pcw), 32'd1);
        run_instr(32'h0020A023, 1'b0, 32'h0, len);
        check("sw cycles", 32'(len), 32'd4);
        trap_test(32'h0000007F, "opcode 7f");
        trap_test(32'h0020C033, "rtype funct3 100");
        bus.Instr = 32'h0020A023;
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        check("sw MEMWR request", 32'({snap.req, snap.mw}), 32'b11);
        cyc(1'b1, 1'b1);
        check("sw rst request", 32'({snap.req, snap.mw}), 32'b00);
        cyc(1'b0, 1'b0);
        check("sw fetch after rst", 32'({snap.req, snap.adr, snap.b}), 32'b1010);
        tc = 0;
        for (int i = 0; i < 3000; i++) begin
            if (q.size() == 0) bus.Instr = rand_instr();
            bus.Zero = 1'($urandom_range(1));
            cyc(($urandom_range(63) == 0) || tc > 12, $urandom_range(3) != 0);
            tc = (q.size() != 0 && q[0] == ST_TRAP) ? tc + 1 : 0;
        end
        run = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
